// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the serial adder sequencer.
// The requester drives operands and start; the sequencer returns busy/done and the result.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice per clock, LSB first,
// with a registered carry linking the slices and a start/busy/done handshake.
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  serial_adder_ctrl_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic               slice_s;
  logic               slice_c;
  logic [WIDTH-1:0]   res_shift;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    slice_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    slice_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

    res_shift            = res_sr_q >> 1;
    res_shift[WIDTH-1]   = slice_s;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_shift;
        carry_d  = slice_c;
        cnt_d    = cnt_q + 1'b1;
        // On the last slice carry_q is the carry into the MSB, so overflow needs no extra register.
        if (cnt_q == LAST) begin
          sum_d   = res_shift;
          cout_d  = slice_c;
          ovf_d   = carry_q ^ slice_c;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed corner cases, handshake
// abuse (start while busy, reset mid-run, back-to-back) and random operations.
module tb_serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
);

  logic clk = 1'b0;
  logic reset;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_sum;
  logic             exp_cout;
  logic             exp_ovf;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
  } vec_t;

  vec_t vecs [7] = '{
    '{32'h35, 32'h4A, 1'b0, 1'b0},
    '{32'hFF, 32'h01, 1'b0, 1'b0},
    '{32'h7F, 32'h01, 1'b0, 1'b0},
    '{32'h00, 32'h00, 1'b1, 1'b0},
    '{32'h20, 32'h10, 1'b0, 1'b1},
    '{32'h10, 32'h20, 1'b0, 1'b1},
    '{32'h80, 32'h01, 1'b1, 1'b1}
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: whole-word arithmetic; overflow from operand/result signs.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub,
                       output logic [WIDTH-1:0] s, output logic co, output logic ov);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bop;
    logic             ci;
    bop  = sub ? ~b : b;
    ci   = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bop} + (WIDTH+1)'(ci);
    s    = full[WIDTH-1:0];
    co   = full[WIDTH];
    ov   = (a[WIDTH-1] == bop[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_noise();
    bus.a   = WIDTH'($urandom());
    bus.b   = WIDTH'($urandom());
    bus.cin = 1'($urandom());
    bus.sub = 1'($urandom());
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_sum"},  32'(bus.sum),  32'(exp_sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    check({tag, "_ovf"},  32'(bus.ovf),  32'(exp_ovf));
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      tick();
      check("idle_done", 32'(bus.done), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_sum_hold", 32'(bus.sum), 32'(exp_sum));
    end
  endtask

  // Issues one request; optionally pulses start or reset on a given busy cycle (1-based).
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub,
                        input int inj_at, input int rst_at);
    logic [WIDTH-1:0] s;
    logic             co, ov;
    int               n;
    bit               aborted;
    model(a, b, cin, sub, s, co, ov);

    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.sub   = sub;
    tick();
    bus.start = 1'b0;
    drive_noise();
    check("accept_busy", 32'(bus.busy), 32'd1);
    check("accept_done", 32'(bus.done), 32'd0);

    n       = 0;
    aborted = 1'b0;
    while (bus.busy && n < WIDTH + 4) begin
      n++;
      check("run_done", 32'(bus.done), 32'd0);
      check("run_sum_hold", 32'(bus.sum), 32'(exp_sum));
      if (n == inj_at) begin
        bus.start = 1'b1;
        bus.a     = WIDTH'(32'hAA);
        bus.b     = WIDTH'(32'h55);
      end
      if (n == rst_at) begin
        reset   = 1'b1;
        aborted = 1'b1;
      end
      tick();
      bus.start = 1'b0;
      reset     = 1'b0;
      drive_noise();
      if (aborted) break;
    end

    if (aborted) begin
      exp_sum  = '0;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check_outputs("abort");
      idle(WIDTH + 2);
    end else begin
      check("busy_len", 32'(n), 32'(WIDTH));
      check("done_pulse", 32'(bus.done), 32'd1);
      check("done_busy", 32'(bus.busy), 32'd0);
      exp_sum  = s;
      exp_cout = co;
      exp_ovf  = ov;
      check_outputs("result");
    end
  endtask

  initial begin
    int k_inj;
    int k_rst;
    k_inj = (WIDTH < 3) ? WIDTH : 3;
    k_rst = (WIDTH < 4) ? WIDTH : 4;

    reset     = 1'b1;
    bus.start = 1'b0;
    drive_noise();
    exp_sum  = '0;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check_outputs("reset");
    reset     = 1'b0;
    bus.start = 1'b0;
    idle(2);

    foreach (vecs[i]) begin
      run_op(WIDTH'(vecs[i].a), WIDTH'(vecs[i].b), vecs[i].cin, vecs[i].sub, -1, -1);
      idle(1);
    end

    // Start pulsed mid-run is neither honoured nor queued.
    run_op(WIDTH'(32'h01), WIDTH'(32'h01), 1'b0, 1'b0, k_inj, -1);
    idle(3);

    // Reset mid-run aborts; a fresh operation then works.
    run_op(WIDTH'($urandom()), WIDTH'($urandom()), 1'b1, 1'b0, -1, k_rst);
    run_op(WIDTH'(32'h35), WIDTH'(32'h4A), 1'b0, 1'b0, -1, -1);
    idle(1);

    // Back-to-back: the second request is issued in the done cycle.
    run_op(WIDTH'(32'h12), WIDTH'(32'h34), 1'b0, 1'b0, -1, -1);
    run_op(WIDTH'(32'hC3), WIDTH'(32'h5A), 1'b0, 1'b1, -1, -1);
    idle(1);

    for (int i = 0; i < 500; i++) begin
      run_op(WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()), 1'($urandom()), -1, -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
